// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM encoding,
// default timing constants for a 100 MHz clock and elaboration helpers.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_HOLD   = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    localparam int CLK_HZ              = 100_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
    localparam int HOLD_CYCLES_DEF     = CLK_HZ / 2;
    localparam int REPEAT_CYCLES_DEF   = CLK_HZ / 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, counter debouncer, press/release
// strobes and an optional hold-to-auto-repeat FSM.
module btn_debounce_ch
    import button_conditioner_pkg::*;
#(
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int               CNT_W    = width_of(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
    end
    if ((REPEAT_EN != 0) && ((HOLD_CYCLES < 1) || (REPEAT_CYCLES < 1))) begin : g_bad_repeat
        $error("btn_debounce_ch: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
    end

    logic             pin_pressed_s;
    logic             sync0_r;
    logic             sync1_r;
    logic             level_r;
    logic             press_r;
    logic             release_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             level_nxt_s;

    assign pin_pressed_s = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

    // Decide whether the synchronized input has been stable long enough to accept.
    always_comb begin
        accept_s    = 1'b0;
        level_nxt_s = level_r;
        if ((sync1_r != level_r) && (cnt_r == CNT_LAST)) begin
            accept_s    = 1'b1;
            level_nxt_s = ~level_r;
        end else begin
            accept_s    = 1'b0;
            level_nxt_s = level_r;
        end
    end

    // Synchronizer, debounce counter, debounced level and edge strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_r   <= 1'b0;
            sync1_r   <= 1'b0;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync0_r   <= pin_pressed_s;
            sync1_r   <= sync0_r;
            level_r   <= level_nxt_s;
            press_r   <= accept_s & ~level_r;
            release_r <= accept_s & level_r;
            if ((sync1_r == level_r) || accept_s) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign btn_level   = level_r;
    assign btn_press   = press_r;
    assign btn_release = release_r;

    if (REPEAT_EN != 0) begin : g_repeat
        localparam int               TMR_W       = width_of(max_int(HOLD_CYCLES, REPEAT_CYCLES));
        localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
        localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

        rpt_state_e       state_r;
        logic [TMR_W-1:0] tmr_r;
        logic             repeat_r;

        // Repeat FSM; it follows the next-cycle level so the release cycle never repeats.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_r  <= RPT_IDLE;
                tmr_r    <= '0;
                repeat_r <= 1'b0;
            end else begin
                repeat_r <= 1'b0;
                case (state_r)
                    RPT_IDLE: begin
                        tmr_r <= '0;
                        if (accept_s && !level_r) begin
                            state_r <= RPT_HOLD;
                        end else begin
                            state_r <= RPT_IDLE;
                        end
                    end
                    RPT_HOLD: begin
                        if (!level_nxt_s) begin
                            state_r <= RPT_IDLE;
                            tmr_r   <= '0;
                        end else if (tmr_r == HOLD_LAST) begin
                            state_r  <= RPT_REPEAT;
                            tmr_r    <= '0;
                            repeat_r <= 1'b1;
                        end else begin
                            tmr_r <= tmr_r + TMR_W'(1);
                        end
                    end
                    RPT_REPEAT: begin
                        if (!level_nxt_s) begin
                            state_r <= RPT_IDLE;
                            tmr_r   <= '0;
                        end else if (tmr_r == REPEAT_LAST) begin
                            tmr_r    <= '0;
                            repeat_r <= 1'b1;
                        end else begin
                            tmr_r <= tmr_r + TMR_W'(1);
                        end
                    end
                    default: begin
                        state_r <= RPT_IDLE;
                        tmr_r   <= '0;
                    end
                endcase
            end
        end

        assign btn_repeat = repeat_r;
    end else begin : g_no_repeat
        assign btn_repeat = 1'b0;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw board buttons into debounced levels and one-cycle
// press/release/auto-repeat strobes; channels are fully independent.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_EN       = 1,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .ACTIVE_LOW     (ACTIVE_LOW),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared every cycle against a history-window reference model.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int D  = 4;
    localparam int H  = 10;
    localparam int R  = 3;
    localparam int HL = D + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_repeat;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: per-channel history of sampled "pressed" values.
    bit            hist [NB][HL];
    bit   [NB-1:0] m_level;
    int            m_press_cyc [NB];
    int            cyc = 0;
    logic [NB-1:0] exp_level;
    logic [NB-1:0] exp_press;
    logic [NB-1:0] exp_release;
    logic [NB-1:0] exp_repeat;

    button_conditioner #(
        .NUM_BTN        (NB),
        .ACTIVE_LOW     (1),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_EN      (1),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // A level change is accepted once D consecutive synchronized samples
    // (which lag the pin by two clocks) all disagree with the current level.
    task automatic model_step(input logic r, input logic [NB-1:0] raw);
        bit all_diff;
        int d;
        cyc++;
        for (int c = 0; c < NB; c++) begin
            exp_press[c]   = 1'b0;
            exp_release[c] = 1'b0;
            exp_repeat[c]  = 1'b0;
            if (r) begin
                for (int k = 0; k < HL; k++) hist[c][k] = 1'b0;
                m_level[c] = 1'b0;
            end else begin
                for (int k = 0; k < HL - 1; k++) hist[c][k] = hist[c][k+1];
                hist[c][HL-1] = ~raw[c];
                all_diff = 1'b1;
                for (int k = 0; k < D; k++) begin
                    if (hist[c][k] == m_level[c]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        exp_press[c]   = 1'b1;
                        m_press_cyc[c] = cyc;
                    end else begin
                        exp_release[c] = 1'b1;
                    end
                end else if (m_level[c]) begin
                    d = cyc - m_press_cyc[c];
                    if (d == H || (d > H && ((d - H) % R) == 0)) exp_repeat[c] = 1'b1;
                end
            end
        end
        exp_level = m_level;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(rst, btn_raw);
        @(negedge clk);
        chk("level",   int'(btn_level),   int'(exp_level));
        chk("press",   int'(btn_press),   int'(exp_press));
        chk("release", int'(btn_release), int'(exp_release));
        chk("repeat",  int'(btn_repeat),  int'(exp_repeat));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until every channel in mask strobes (kind 0 = press, 1 = release).
    task automatic wait_strobe(input logic [NB-1:0] mask, input int kind, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((((kind == 0) ? btn_press : btn_release) & mask) == mask) begin
                lat = i;
                break;
            end
        end
    endtask

    int lat;
    int cnt;
    int run [NB];

    initial begin
        rst     = 1'b1;
        btn_raw = 2'b11;

        // Reset and quiet idle
        ticks(3);
        chk("rst_outs", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            cnt += int'(|{btn_level, btn_press, btn_release, btn_repeat});
        end
        chk("idle_quiet", cnt, 0);

        // Clean press and release on channel 0
        btn_raw = 2'b10;
        wait_strobe(2'b01, 0, lat);
        chk("press_lat", lat, D + 2);
        chk("press_lvl", int'(btn_level), 1);
        tick();
        chk("press_width", int'(btn_press), 0);
        ticks(7);
        btn_raw = 2'b11;
        wait_strobe(2'b01, 1, lat);
        chk("release_lat", lat, D + 2);
        chk("release_lvl", int'(btn_level), 0);
        ticks(10);

        // Bounce on channel 0: toggling every 2 clks never settles
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            for (int j = 0; j < 2; j++) begin
                tick();
                cnt += int'(btn_level[0] | btn_press[0] | btn_release[0]);
            end
        end
        btn_raw[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(btn_level[0] | btn_press[0] | btn_release[0]);
        end
        chk("bounce_quiet", cnt, 0);

        // Auto-repeat on channel 1: strobes at press+10, +13, ... +28
        btn_raw = 2'b01;
        wait_strobe(2'b10, 0, lat);
        chk("rpt_press_lat", lat, D + 2);
        cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (btn_repeat[1]) begin
                cnt++;
                chk("rpt_offset", (i - H) % R, 0);
            end
        end
        chk("rpt_count", cnt, 7);
        btn_raw = 2'b11;
        wait_strobe(2'b10, 1, lat);
        chk("rpt_release_lat", lat, D + 2);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            cnt += int'(btn_repeat[1]);
        end
        chk("rpt_after_release", cnt, 0);

        // Simultaneous press on both channels
        btn_raw = 2'b00;
        wait_strobe(2'b11, 0, lat);
        chk("both_lat", lat, D + 2);
        chk("both_press", int'(btn_press), 3);
        ticks(15);

        // Reset while held in REPEAT, then re-debounce after release of reset
        rst = 1'b1;
        tick();
        chk("mid_rst0", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        tick();
        chk("mid_rst1", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        rst = 1'b0;
        wait_strobe(2'b11, 0, lat);
        chk("rst_repress_lat", lat, D + 2);
        btn_raw = 2'b11;
        ticks(10);

        // Random activity with one reset pulse in the middle
        run[0] = 0;
        run[1] = 0;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (run[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    run[c]     = int'($urandom_range(1, 25));
                end else begin
                    run[c]--;
                end
            end
            rst = (i == 300 || i == 301) ? 1'b1 : 1'b0;
            tick();
        end
        rst     = 1'b0;
        btn_raw = 2'b11;
        ticks(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
